// File: rtl/ili9341_init_sequencer.sv
// Power-up sequencer for the ILI9341 panel. It pulses the panel reset line, then replays a
// fixed command/data/delay script into the byte serializer over a valid/ready handshake.
module ili9341_init_sequencer #(
  parameter int unsigned TICKS_PER_MS = 50000,
  parameter int unsigned RST_LOW_MS   = 10,
  parameter int unsigned RST_WAIT_MS  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       byte_ready,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       lcd_rst,
  output logic       busy,
  output logic       init_done,
  output logic [3:0] debug_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_LOW, S_RST_WAIT, S_FETCH, S_SEND, S_DELAY, S_DONE
  } state_t;

  localparam logic [1:0] T_CMD = 2'b00;
  localparam logic [1:0] T_DAT = 2'b01;
  localparam logic [1:0] T_DLY = 2'b10;
  localparam logic [1:0] T_END = 2'b11;

  // A zero-length wait would underflow the down-counter, so every wait lasts at least one cycle.
  function automatic logic [31:0] sat_ticks(input logic [63:0] prod);
    if (prod == 64'd0)
      return 32'd1;
    else if (prod > 64'h0000_0000_FFFF_FFFF)
      return 32'hFFFF_FFFF;
    else
      return prod[31:0];
  endfunction

  function automatic logic [9:0] rom(input logic [3:0] a);
    case (a)
      4'd0:    return {T_CMD, 8'h01};
      4'd1:    return {T_DLY, 8'd120};
      4'd2:    return {T_CMD, 8'h11};
      4'd3:    return {T_DLY, 8'd120};
      4'd4:    return {T_CMD, 8'h3A};
      4'd5:    return {T_DAT, 8'h55};
      4'd6:    return {T_CMD, 8'h36};
      4'd7:    return {T_DAT, 8'h48};
      4'd8:    return {T_CMD, 8'h29};
      4'd9:    return {T_DLY, 8'd20};
      default: return {T_END, 8'h00};
    endcase
  endfunction

  localparam logic [31:0] L_TICKS = sat_ticks(64'(RST_LOW_MS) * 64'(TICKS_PER_MS));
  localparam logic [31:0] W_TICKS = sat_ticks(64'(RST_WAIT_MS) * 64'(TICKS_PER_MS));

  state_t      state;
  logic [31:0] cnt;
  logic [3:0]  idx;
  logic [9:0]  entry;

  assign entry     = rom(idx);
  assign debug_idx = idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 32'd0;
      idx        <= 4'd0;
      lcd_rst    <= 1'b1;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_dc    <= 1'b0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RST_LOW;
            idx       <= 4'd0;
            cnt       <= L_TICKS;
            lcd_rst   <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
          end
        end
        S_RST_LOW: begin
          if (cnt == 32'd1) begin
            state   <= S_RST_WAIT;
            cnt     <= W_TICKS;
            lcd_rst <= 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_RST_WAIT: begin
          if (cnt == 32'd1) begin
            state <= S_FETCH;
            cnt   <= 32'd0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_FETCH: begin
          case (entry[9:8])
            T_CMD, T_DAT: begin
              state      <= S_SEND;
              byte_valid <= 1'b1;
              byte_data  <= entry[7:0];
              byte_dc    <= entry[8];
            end
            T_DLY: begin
              state <= S_DELAY;
              cnt   <= sat_ticks(64'(entry[7:0]) * 64'(TICKS_PER_MS));
            end
            default: begin
              state     <= S_DONE;
              busy      <= 1'b0;
              init_done <= 1'b1;
            end
          endcase
        end
        S_SEND: begin
          // Payload stays frozen until the serializer takes it.
          if (byte_ready) begin
            state      <= S_FETCH;
            byte_valid <= 1'b0;
            idx        <= idx + 4'd1;
          end
        end
        S_DELAY: begin
          if (cnt == 32'd1) begin
            state <= S_FETCH;
            cnt   <= 32'd0;
            idx   <= idx + 4'd1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ili9341_init_sequencer.sv
// Scoreboard bench for ili9341_init_sequencer: expected bytes and their handshake spacing are
// queued by the stimulus and checked by an independent handshake monitor.
module tb_ili9341_init_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       byte_ready = 1'b1;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       lcd_rst;
  logic       busy;
  logic       init_done;
  logic [3:0] debug_idx;

  ili9341_init_sequencer #(
    .TICKS_PER_MS(2),
    .RST_LOW_MS  (1),
    .RST_WAIT_MS (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .byte_ready(byte_ready),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_dc   (byte_dc),
    .lcd_rst   (lcd_rst),
    .busy      (busy),
    .init_done (init_done),
    .debug_idx (debug_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dc;
    logic [7:0] data;
    int         gap;   // cycles since previous handshake (or since start); -1 = unchecked
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_hs = 0;
  localparam int LIMIT = 3000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Handshake monitor
  always @(negedge clk) begin
    if (!reset && byte_valid && byte_ready) begin
      if (q.size() == 0) begin
        chk("extra_byte", {23'd0, byte_dc, byte_data}, 32'h1FF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("byte_data", {24'd0, byte_data}, {24'd0, e.data});
        chk("byte_dc", {31'd0, byte_dc}, {31'd0, e.dc});
        if (e.gap >= 0) chk("hs_gap", cyc - last_hs, e.gap);
      end
      last_hs = cyc;
    end
  end

  task automatic push(input logic dc, input logic [7:0] d, input int gap);
    exp_t e;
    e.dc = dc; e.data = d; e.gap = gap;
    q.push_back(e);
  endtask

  // 5 = FETCH after L+W reset cycles; 243 = FETCH + 240-cycle DLY + FETCH + SEND; 2 = FETCH + SEND.
  task automatic push_full(input int gap_3a);
    push(1'b0, 8'h01, 5);
    push(1'b0, 8'h11, 243);
    push(1'b0, 8'h3A, gap_3a);
    push(1'b1, 8'h55, 2);
    push(1'b0, 8'h36, 2);
    push(1'b1, 8'h48, 2);
    push(1'b0, 8'h29, 2);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    last_hs = cyc;
    chk("rst_low_0", {31'd0, lcd_rst}, 32'd0);
    chk("done_clr", {31'd0, init_done}, 32'd0);
    chk("busy_set", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("rst_low_1", {31'd0, lcd_rst}, 32'd0);
    @(negedge clk);
    chk("rst_release", {31'd0, lcd_rst}, 32'd1);
  endtask

  task automatic wait_idx(input logic [3:0] v, input string nm);
    int n = 0;
    while (debug_idx !== v && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, n < LIMIT}, 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (byte_valid !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, n < LIMIT}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (init_done !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'd0, n < LIMIT}, 32'd1);
    // FETCH(DLY) + 40 DELAY cycles + FETCH(END), then DONE is visible.
    chk("done_latency", cyc - last_hs, 32'd43);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("queue_empty", q.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_lcd_rst", {31'd0, lcd_rst}, 32'd1);
    chk("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    chk("rst_idx", {28'd0, debug_idx}, 32'd0);
    chk("rst_data", {23'd0, byte_dc, byte_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full sequence, ready tied high
    push_full(243);
    pulse_start();
    wait_done();

    // Re-init from DONE, with an ignored start and backpressure on 0x3A
    repeat (3) @(negedge clk);
    push_full(-1);
    pulse_start();
    wait_idx(4'd1, "wait_idx1");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ign_lcd_rst", {31'd0, lcd_rst}, 32'd1);
      chk("ign_busy", {31'd0, busy}, 32'd1);
      chk("ign_idx", {28'd0, debug_idx}, 32'd1);
    end
    wait_idx(4'd3, "wait_idx3");
    byte_ready = 1'b0;
    wait_valid("wait_3a");
    repeat (10) begin
      chk("stall_valid", {31'd0, byte_valid}, 32'd1);
      chk("stall_data", {24'd0, byte_data}, 32'h3A);
      chk("stall_dc", {31'd0, byte_dc}, 32'd0);
      @(negedge clk);
    end
    byte_ready = 1'b1;
    wait_done();

    // Reset while 0x36 is pending
    push(1'b0, 8'h01, 5);
    push(1'b0, 8'h11, 243);
    push(1'b0, 8'h3A, 243);
    push(1'b1, 8'h55, 2);
    pulse_start();
    wait_idx(4'd6, "wait_idx6");
    byte_ready = 1'b0;
    wait_valid("wait_36");
    @(negedge clk);
    chk("hold_36", {24'd0, byte_data}, 32'h36);
    chk("hold_valid", {31'd0, byte_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_valid", {31'd0, byte_valid}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_lcd_rst", {31'd0, lcd_rst}, 32'd1);
    chk("mid_idx", {28'd0, debug_idx}, 32'd0);
    chk("mid_q", q.size(), 32'd0);
    reset = 1'b0;
    byte_ready = 1'b1;
    push_full(243);
    pulse_start();
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
